iiitb_coin_acceptor: RTL and testbench

//  Upstream front end of the vending FSM: turns three raw coin-sensor lines into

---
 rtl/iiitb_coin_acceptor.sv | 234 +++++++++++++++++++++++
 tb/tb_iiitb_coin_acceptor.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iiitb_coin_acceptor.sv
// iiitb_coin_acceptor
// Front end for the vending FSM. Three raw, asynchronous coin sensor lines are
// synchronised, debounced and validated; each accepted insertion becomes a single
// one-cycle coin code on 'coin'. Simultaneous activity on more than one sensor is
// discarded with a one-cycle 'reject' pulse. While the vending FSM asserts 'hold',
// one qualified coin is parked and delivered once 'hold' drops.
//
// Coin codes: 001 nickel, 010 dime, 101 quarter, 000 no coin.

module iiitb_coin_acceptor #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int RELEASE_CYCLES  = 2,
    parameter int CNT_W           = 3
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       nickel_in,
    input  logic       dime_in,
    input  logic       quarter_in,
    input  logic       hold,
    output logic [2:0] coin,
    output logic       reject,
    output logic       busy,
    output logic [7:0] coin_count
);

    // State encoding
    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_QUALIFY = 3'd1;
    localparam logic [2:0] ST_PENDING = 3'd2;
    localparam logic [2:0] ST_EMIT    = 3'd3;
    localparam logic [2:0] ST_RELEASE = 3'd4;

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] DEB_MAX  = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] REL_MAX  = CNT_W'(RELEASE_CYCLES);

    // True when exactly one sensor is active in the vector
    function automatic logic is_one_hot(input logic [2:0] v);
        logic r;
        case (v)
            3'b001:  r = 1'b1;
            3'b010:  r = 1'b1;
            3'b100:  r = 1'b1;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    // Maps a single-sensor vector {quarter,dime,nickel} to the FSM coin code
    function automatic logic [2:0] coin_code(input logic [2:0] v);
        logic [2:0] r;
        case (v)
            3'b001:  r = 3'b001;
            3'b010:  r = 3'b010;
            3'b100:  r = 3'b101;
            default: r = 3'b000;
        endcase
        return r;
    endfunction

    // Synchroniser stages and pipeline-valid tracking
    logic [2:0]       sync1_r;
    logic [2:0]       sync2_r;
    logic [1:0]       sync_vld_r;
    logic [2:0]       s_s;
    logic             s_valid_s;

    // FSM registers
    logic [2:0]       state_r;
    logic [CNT_W-1:0] cnt_r;
    logic [2:0]       v_r;
    logic [2:0]       coin_r;
    logic             reject_r;
    logic             busy_r;
    logic [7:0]       coin_count_r;

    // Next-state values
    logic [2:0]       state_nxt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [CNT_W-1:0] cnt_inc_s;
    logic [2:0]       v_nxt;
    logic [2:0]       coin_nxt;
    logic             reject_nxt;
    logic [7:0]       count_nxt;
    logic [2:0]       dec_state_s;
    logic             dec_reject_s;

    assign s_s       = sync2_r;
    // sync2 only reflects a real sensor sample two edges after reset is released;
    // before that its zeros are reset artefacts and must not count as a release.
    assign s_valid_s = sync_vld_r[1];
    assign cnt_inc_s = cnt_r + CNT_ONE;

    // Two-flop synchroniser for the raw sensor lines, plus its fill tracker
    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_r    <= 3'b000;
            sync2_r    <= 3'b000;
            sync_vld_r <= 2'b00;
        end else begin
            sync1_r    <= {quarter_in, dime_in, nickel_in};
            sync2_r    <= sync1_r;
            sync_vld_r <= {sync_vld_r[0], 1'b1};
        end
    end

    // Outcome of a completed debounce: the qualified vector always equals s here
    always_comb begin
        dec_state_s  = ST_RELEASE;
        dec_reject_s = 1'b0;
        if (is_one_hot(s_s)) begin
            if (hold) begin
                dec_state_s = ST_PENDING;
            end else begin
                dec_state_s = ST_EMIT;
            end
        end else begin
            dec_state_s  = ST_RELEASE;
            dec_reject_s = 1'b1;
        end
    end

    // Acceptor FSM next-state and next-output logic
    always_comb begin
        state_nxt  = state_r;
        cnt_nxt    = cnt_r;
        v_nxt      = v_r;
        coin_nxt   = 3'b000;
        reject_nxt = 1'b0;
        count_nxt  = coin_count_r;
        case (state_r)
            ST_IDLE: begin
                if (s_s != 3'b000) begin
                    v_nxt = s_s;
                    if (DEB_MAX <= CNT_ONE) begin
                        state_nxt  = dec_state_s;
                        reject_nxt = dec_reject_s;
                        cnt_nxt    = CNT_ZERO;
                    end else begin
                        state_nxt = ST_QUALIFY;
                        cnt_nxt   = CNT_ONE;
                    end
                end else begin
                    cnt_nxt = CNT_ZERO;
                end
            end
            ST_QUALIFY: begin
                if (s_s == 3'b000) begin
                    // Glitch shorter than the debounce window: drop silently
                    state_nxt = ST_IDLE;
                    cnt_nxt   = CNT_ZERO;
                end else if (s_s != v_r) begin
                    // Sensor pattern changed: restart qualification on the new one
                    v_nxt = s_s;
                    if (DEB_MAX <= CNT_ONE) begin
                        state_nxt  = dec_state_s;
                        reject_nxt = dec_reject_s;
                        cnt_nxt    = CNT_ZERO;
                    end else begin
                        cnt_nxt = CNT_ONE;
                    end
                end else if (cnt_inc_s >= DEB_MAX) begin
                    state_nxt  = dec_state_s;
                    reject_nxt = dec_reject_s;
                    cnt_nxt    = CNT_ZERO;
                end else begin
                    cnt_nxt = cnt_inc_s;
                end
            end
            ST_PENDING: begin
                // Sensors are ignored; the parked coin waits for hold to drop
                if (!hold) begin
                    state_nxt = ST_EMIT;
                end else begin
                    state_nxt = ST_PENDING;
                end
            end
            ST_EMIT: begin
                coin_nxt  = coin_code(v_r);
                count_nxt = coin_count_r + 8'd1;
                state_nxt = ST_RELEASE;
                cnt_nxt   = CNT_ZERO;
            end
            ST_RELEASE: begin
                if (!s_valid_s) begin
                    cnt_nxt = cnt_r;
                end else if (s_s == 3'b000) begin
                    if (cnt_inc_s >= REL_MAX) begin
                        state_nxt = ST_IDLE;
                        cnt_nxt   = CNT_ZERO;
                    end else begin
                        cnt_nxt = cnt_inc_s;
                    end
                end else begin
                    // Line still (or again) active: a held coin never re-triggers
                    cnt_nxt = CNT_ZERO;
                end
            end
            default: begin
                state_nxt = ST_RELEASE;
                cnt_nxt   = CNT_ZERO;
            end
        endcase
    end

    // FSM state and registered outputs; reset drops any parked coin
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r      <= ST_RELEASE;
            cnt_r        <= CNT_ZERO;
            v_r          <= 3'b000;
            coin_r       <= 3'b000;
            reject_r     <= 1'b0;
            busy_r       <= 1'b1;
            coin_count_r <= 8'd0;
        end else begin
            state_r      <= state_nxt;
            cnt_r        <= cnt_nxt;
            v_r          <= v_nxt;
            coin_r       <= coin_nxt;
            reject_r     <= reject_nxt;
            busy_r       <= (state_nxt != ST_IDLE);
            coin_count_r <= count_nxt;
        end
    end

    assign coin       = coin_r;
    assign reject     = reject_r;
    assign busy       = busy_r;
    assign coin_count = coin_count_r;

endmodule

// File: tb/tb_iiitb_coin_acceptor.sv
// Directed bench for iiitb_coin_acceptor (default parameters).
// Edge numbering inside each test: edge 1 is the first rising edge that samples
// the newly driven raw line. Outputs are sampled 1 ns after each rising edge.

module tb_iiitb_coin_acceptor;

    logic       clock = 1'b0;
    logic       reset;
    logic       nickel_in;
    logic       dime_in;
    logic       quarter_in;
    logic       hold;
    logic [2:0] coin;
    logic       reject;
    logic       busy;
    logic [7:0] coin_count;

    int compared     = 0;
    int mismatched   = 0;
    int coin_pulses  = 0;
    int rej_pulses   = 0;
    int overlap_errs = 0;
    int bad_codes    = 0;

    always #5 clock = ~clock;

    iiitb_coin_acceptor dut (
        .clock      (clock),
        .reset      (reset),
        .nickel_in  (nickel_in),
        .dime_in    (dime_in),
        .quarter_in (quarter_in),
        .hold       (hold),
        .coin       (coin),
        .reject     (reject),
        .busy       (busy),
        .coin_count (coin_count)
    );

    // Output monitor: counts pulses and watches for illegal output combinations
    always @(negedge clock) begin
        if (coin != 3'b000) coin_pulses++;
        if (reject) rej_pulses++;
        if ((coin != 3'b000) && reject) overlap_errs++;
        if ((coin == 3'b011) || (coin == 3'b100)) bad_codes++;
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; nickel_in = 1'b0; dime_in = 1'b0; quarter_in = 1'b0; hold = 1'b0;
        repeat (3) step();
        compared++;
        if (coin !== 3'b000) begin mismatched++; $display("FAIL reset_coin: got %b want 000", coin); end
        compared++;
        if (reject !== 1'b0) begin mismatched++; $display("FAIL reset_reject: got %b want 0", reject); end
        compared++;
        if (busy !== 1'b1) begin mismatched++; $display("FAIL reset_busy: got %b want 1", busy); end
        compared++;
        if (coin_count !== 8'd0) begin mismatched++; $display("FAIL reset_count: got %0d want 0", coin_count); end
        reset = 1'b0;
        step(); step();
        compared++;
        if (busy !== 1'b1) begin mismatched++; $display("FAIL reset_busy_r2: got %b want 1", busy); end
        step(); step();
        compared++;
        if (busy !== 1'b0) begin mismatched++; $display("FAIL reset_idle_r4: got %b want 0", busy); end
    endtask

    task automatic test_nickel();
        int p0;
        p0 = coin_pulses;
        nickel_in = 1'b1;
        for (int e = 1; e <= 16; e++) begin
            if (e == 11) nickel_in = 1'b0;
            step();
            if (e == 6) begin
                compared++;
                if (coin !== 3'b000) begin mismatched++; $display("FAIL nickel_early: got %b want 000", coin); end
            end
            if (e == 7) begin
                compared++;
                if (coin !== 3'b001) begin mismatched++; $display("FAIL nickel_coin: got %b want 001", coin); end
                compared++;
                if (coin_count !== 8'd1) begin mismatched++; $display("FAIL nickel_count: got %0d want 1", coin_count); end
            end
            if (e == 8) begin
                compared++;
                if (coin !== 3'b000) begin mismatched++; $display("FAIL nickel_width: got %b want 000", coin); end
            end
            if (e == 13) begin
                compared++;
                if (busy !== 1'b1) begin mismatched++; $display("FAIL nickel_busy13: got %b want 1", busy); end
            end
            if (e == 14) begin
                compared++;
                if (busy !== 1'b0) begin mismatched++; $display("FAIL nickel_busy14: got %b want 0", busy); end
            end
        end
        compared++;
        if (coin_pulses - p0 !== 1) begin mismatched++; $display("FAIL nickel_pulses: got %0d want 1", coin_pulses - p0); end
    endtask

    task automatic test_glitch();
        int p0, r0;
        p0 = coin_pulses; r0 = rej_pulses;
        dime_in = 1'b1;
        for (int e = 1; e <= 12; e++) begin
            if (e == 3) dime_in = 1'b0;
            step();
            if (e == 3) begin
                compared++;
                if (busy !== 1'b1) begin mismatched++; $display("FAIL glitch_busy3: got %b want 1", busy); end
            end
            if (e == 5) begin
                compared++;
                if (busy !== 1'b0) begin mismatched++; $display("FAIL glitch_busy5: got %b want 0", busy); end
            end
        end
        compared++;
        if (coin_pulses != p0) begin mismatched++; $display("FAIL glitch_coin: got %0d pulses want 0", coin_pulses - p0); end
        compared++;
        if (rej_pulses != r0) begin mismatched++; $display("FAIL glitch_reject: got %0d pulses want 0", rej_pulses - r0); end
        compared++;
        if (coin_count !== 8'd1) begin mismatched++; $display("FAIL glitch_count: got %0d want 1", coin_count); end
    endtask

    task automatic test_reject();
        int p0, r0;
        p0 = coin_pulses; r0 = rej_pulses;
        dime_in = 1'b1; quarter_in = 1'b1;
        for (int e = 1; e <= 16; e++) begin
            if (e == 9) begin dime_in = 1'b0; quarter_in = 1'b0; end
            step();
            if (e == 5) begin
                compared++;
                if (reject !== 1'b0) begin mismatched++; $display("FAIL reject_early: got %b want 0", reject); end
            end
            if (e == 6) begin
                compared++;
                if (reject !== 1'b1) begin mismatched++; $display("FAIL reject_pulse: got %b want 1", reject); end
                compared++;
                if (coin !== 3'b000) begin mismatched++; $display("FAIL reject_coin: got %b want 000", coin); end
            end
            if (e == 7) begin
                compared++;
                if (reject !== 1'b0) begin mismatched++; $display("FAIL reject_width: got %b want 0", reject); end
            end
        end
        compared++;
        if (rej_pulses - r0 !== 1) begin mismatched++; $display("FAIL reject_count: got %0d pulses want 1", rej_pulses - r0); end
        compared++;
        if (coin_pulses != p0) begin mismatched++; $display("FAIL reject_nocoin: got %0d pulses want 0", coin_pulses - p0); end
        compared++;
        if (coin_count !== 8'd1) begin mismatched++; $display("FAIL reject_cnt: got %0d want 1", coin_count); end
        compared++;
        if (busy !== 1'b0) begin mismatched++; $display("FAIL reject_idle: got %b want 0", busy); end
    endtask

    task automatic test_hold();
        int p0;
        p0 = coin_pulses;
        hold = 1'b1; quarter_in = 1'b1;
        for (int e = 1; e <= 26; e++) begin
            if (e == 7) quarter_in = 1'b0;
            if (e == 21) hold = 1'b0;
            step();
            if (e == 8) begin
                compared++;
                if (busy !== 1'b1) begin mismatched++; $display("FAIL hold_busy: got %b want 1", busy); end
            end
            if (e == 21) begin
                compared++;
                if (coin_pulses != p0) begin mismatched++; $display("FAIL hold_blocked: got %0d pulses want 0", coin_pulses - p0); end
                compared++;
                if (coin !== 3'b000) begin mismatched++; $display("FAIL hold_e21: got %b want 000", coin); end
            end
            if (e == 22) begin
                compared++;
                if (coin !== 3'b101) begin mismatched++; $display("FAIL hold_coin: got %b want 101", coin); end
                compared++;
                if (coin_count !== 8'd2) begin mismatched++; $display("FAIL hold_count: got %0d want 2", coin_count); end
            end
            if (e == 23) begin
                compared++;
                if (coin !== 3'b000) begin mismatched++; $display("FAIL hold_width: got %b want 000", coin); end
            end
        end
        compared++;
        if (coin_pulses - p0 !== 1) begin mismatched++; $display("FAIL hold_pulses: got %0d want 1", coin_pulses - p0); end
        compared++;
        if (busy !== 1'b0) begin mismatched++; $display("FAIL hold_idle: got %b want 0", busy); end
    endtask

    task automatic test_stuck_reset();
        int p0;
        p0 = coin_pulses;
        nickel_in = 1'b1;
        step(); step();
        reset = 1'b1;
        repeat (3) step();
        reset = 1'b0;
        repeat (8) step();
        compared++;
        if (coin_pulses != p0) begin mismatched++; $display("FAIL stuck_nocoin: got %0d pulses want 0", coin_pulses - p0); end
        compared++;
        if (coin_count !== 8'd0) begin mismatched++; $display("FAIL stuck_count0: got %0d want 0", coin_count); end
        nickel_in = 1'b0;
        step(); step();
        nickel_in = 1'b1;
        for (int e = 1; e <= 12; e++) begin
            if (e == 7) nickel_in = 1'b0;
            step();
            if (e == 7) begin
                compared++;
                if (coin !== 3'b001) begin mismatched++; $display("FAIL stuck_coin: got %b want 001", coin); end
                compared++;
                if (coin_count !== 8'd1) begin mismatched++; $display("FAIL stuck_count1: got %0d want 1", coin_count); end
            end
        end
        compared++;
        if (coin_pulses - p0 !== 1) begin mismatched++; $display("FAIL stuck_pulses: got %0d want 1", coin_pulses - p0); end
    endtask

    task automatic test_reset_pending();
        int p0;
        hold = 1'b1; quarter_in = 1'b1;
        repeat (6) step();
        quarter_in = 1'b0;
        step(); step();
        p0 = coin_pulses;
        reset = 1'b1;
        step();
        compared++;
        if (coin_count !== 8'd0) begin mismatched++; $display("FAIL rstpend_count: got %0d want 0", coin_count); end
        compared++;
        if (busy !== 1'b1) begin mismatched++; $display("FAIL rstpend_busy: got %b want 1", busy); end
        step();
        reset = 1'b0; hold = 1'b0;
        repeat (10) step();
        compared++;
        if (coin_pulses != p0) begin mismatched++; $display("FAIL rstpend_dropped: got %0d pulses want 0", coin_pulses - p0); end
        compared++;
        if (busy !== 1'b0) begin mismatched++; $display("FAIL rstpend_idle: got %b want 0", busy); end
    endtask

    task automatic test_back_to_back();
        int p0;
        reset = 1'b1;
        step(); step();
        reset = 1'b0;
        repeat (4) step();
        p0 = coin_pulses;
        for (int n = 1; n <= 256; n++) begin
            nickel_in = 1'b1;
            repeat (6) step();
            nickel_in = 1'b0;
            repeat (4) step();
            if (n == 255) begin
                compared++;
                if (coin_count !== 8'd255) begin mismatched++; $display("FAIL b2b_count255: got %0d want 255", coin_count); end
            end
        end
        compared++;
        if (coin_count !== 8'd0) begin mismatched++; $display("FAIL b2b_wrap: got %0d want 0", coin_count); end
        compared++;
        if (coin_pulses - p0 !== 256) begin mismatched++; $display("FAIL b2b_pulses: got %0d want 256", coin_pulses - p0); end
    endtask

    task automatic test_protocol();
        compared++;
        if (overlap_errs != 0) begin mismatched++; $display("FAIL coin_reject_overlap: got %0d want 0", overlap_errs); end
        compared++;
        if (bad_codes != 0) begin mismatched++; $display("FAIL illegal_code: got %0d want 0", bad_codes); end
    endtask

    initial begin
        test_reset();
        test_nickel();
        test_glitch();
        test_reject();
        test_hold();
        test_stuck_reset();
        test_reset_pending();
        test_back_to_back();
        test_protocol();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
